// File: rtl/alu_writeback.sv
// rtl/alu_writeback.sv - ALU result writeback: accumulator, flags and output result FIFO
module alu_writeback #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_q,
    input  logic             in_cout,
    input  logic             wr_acc,
    input  logic             wr_carry,
    input  logic             wr_out,
    output logic [WIDTH-1:0] acc,
    output logic             carry,
    output logic             zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_q,
    output logic             out_cout
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem_q [DEPTH];
    logic             r_mem_c [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_acc;
    logic             r_carry;
    logic             r_zero;
    // Last popped head, shown while empty so out_q/out_cout stay stable.
    logic [WIDTH-1:0] r_hold_q;
    logic             r_hold_c;

    logic w_accept;
    logic w_push;
    logic w_pop;
    logic w_out_valid;

    assign in_ready    = (r_count != CW'(DEPTH));
    assign w_out_valid = (r_count != CW'(0));
    assign w_accept    = in_valid & in_ready;
    assign w_push      = w_accept & wr_out;
    assign w_pop       = w_out_valid & out_ready;

    assign acc       = r_acc;
    assign carry     = r_carry;
    assign zero      = r_zero;
    assign out_valid = w_out_valid;
    assign out_q     = w_out_valid ? r_mem_q[r_rptr] : r_hold_q;
    assign out_cout  = w_out_valid ? r_mem_c[r_rptr] : r_hold_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_carry  <= 1'b0;
            r_zero   <= 1'b1;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_hold_q <= '0;
            r_hold_c <= 1'b0;
        end else begin
            if (w_accept && wr_acc) begin
                r_acc  <= in_q;
                r_zero <= (in_q == '0);
            end
            if (w_accept && wr_carry) begin
                r_carry <= in_cout;
            end
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr   <= r_rptr + PW'(1);
                r_hold_q <= r_mem_q[r_rptr];
                r_hold_c <= r_mem_c[r_rptr];
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Storage needs no reset: it is never observed until written.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem_q[r_wptr] <= in_q;
            r_mem_c[r_wptr] <= in_cout;
        end
    end
endmodule

// File: tb/tb_alu_writeback.sv
// tb/tb_alu_writeback.sv - self-checking bench for alu_writeback against a queue-based model
module tb_alu_writeback;
    localparam int WIDTH = 8;
    localparam int DEPTH = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_q;
    logic             in_cout;
    logic             wr_acc;
    logic             wr_carry;
    logic             wr_out;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic             zero;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_q;
    logic             out_cout;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    logic [WIDTH:0]   m_fifo [$];
    logic [WIDTH-1:0] m_acc;
    logic             m_carry;
    logic             m_zero;
    logic [WIDTH:0]   m_last;

    always #5 clk = ~clk;

    alu_writeback #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_q(in_q), .in_cout(in_cout),
        .wr_acc(wr_acc), .wr_carry(wr_carry), .wr_out(wr_out),
        .acc(acc), .carry(carry), .zero(zero),
        .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q), .out_cout(out_cout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_model();
        logic [WIDTH:0] head;
        head = (m_fifo.size() > 0) ? m_fifo[0] : m_last;
        check("in_ready", in_ready, m_fifo.size() < DEPTH);
        check("out_valid", out_valid, m_fifo.size() > 0);
        check("out_q", out_q, head[WIDTH:1]);
        check("out_cout", out_cout, head[0]);
        check("acc", acc, m_acc);
        check("carry", carry, m_carry);
        check("zero", zero, m_zero);
    endtask

    // Drive one cycle of inputs, advance the model, then compare after the edge.
    task automatic step(input logic r, input logic iv, input logic [WIDTH-1:0] q, input logic c,
                        input logic wa, input logic wc, input logic wo, input logic ordy);
        logic acc_ok;
        logic pop;
        rst = r; in_valid = iv; in_q = q; in_cout = c;
        wr_acc = wa; wr_carry = wc; wr_out = wo; out_ready = ordy;
        if (r) begin
            m_fifo.delete();
            m_acc = '0; m_carry = 1'b0; m_zero = 1'b1; m_last = '0;
        end else begin
            acc_ok = iv && (m_fifo.size() < DEPTH);
            pop    = (m_fifo.size() > 0) && ordy;
            if (pop) m_last = m_fifo.pop_front();
            if (acc_ok && wa) begin m_acc = q; m_zero = (q == 0); end
            if (acc_ok && wc) m_carry = c;
            if (acc_ok && wo) m_fifo.push_back({q, c});
        end
        @(negedge clk);
        check_model();
    endtask

    initial begin
        @(negedge clk);
        // reset held two cycles with every write request active
        step(1, 1, 8'hFF, 1, 1, 1, 1, 0);
        step(1, 1, 8'hFF, 1, 1, 1, 1, 0);
        check("rst_acc", acc, 0);
        check("rst_zero", zero, 1);
        check("rst_in_ready", in_ready, 1);

        // accumulator and flags
        step(0, 1, 8'h00, 1, 1, 1, 0, 0);
        check("acc00_zero", zero, 1);
        check("acc00_carry", carry, 1);
        step(0, 1, 8'h5A, 0, 1, 0, 0, 0);
        check("acc5a", acc, 8'h5A);
        check("carry_kept", carry, 1);

        // fill and stall
        step(0, 1, 8'h11, 0, 0, 0, 1, 0);
        step(0, 1, 8'h22, 1, 0, 0, 1, 0);
        check("full_in_ready", in_ready, 0);
        check("full_head", out_q, 8'h11);
        step(0, 1, 8'h33, 0, 1, 0, 1, 0);
        check("blocked_acc", acc, 8'h5A);
        check("stall_head", out_q, 8'h11);

        // full with simultaneous ready: pop only, then accept
        step(0, 1, 8'h33, 0, 0, 0, 1, 1);
        check("pop_head22", out_q, 8'h22);
        check("reopen", in_ready, 1);
        step(0, 1, 8'h33, 0, 0, 0, 1, 0);
        step(0, 0, 8'h00, 0, 0, 0, 0, 1);
        check("drain33", out_q, 8'h33);
        step(0, 0, 8'h00, 0, 0, 0, 0, 1);
        check("drained", out_valid, 0);

        // streaming across pointer wrap
        for (int i = 1; i <= 8; i++) begin
            step(0, 1, WIDTH'(i), i[0], 0, 0, 1, 1);
            check("stream_q", out_q, i);
        end
        step(0, 0, 8'h00, 0, 0, 0, 0, 1);
        check("stream_empty", out_valid, 0);

        // reset mid-operation
        step(0, 1, 8'hC3, 1, 1, 1, 1, 0);
        step(0, 1, 8'h3C, 0, 0, 0, 1, 0);
        step(1, 0, 8'h00, 0, 0, 0, 0, 0);
        check("midrst_valid", out_valid, 0);
        check("midrst_carry", carry, 0);
        step(0, 1, 8'hA5, 1, 0, 0, 1, 0);
        check("after_rst_head", out_q, 8'hA5);
        step(0, 0, 8'h00, 0, 0, 0, 0, 1);
        check("after_rst_single", out_valid, 0);

        // randomized traffic with occasional reset
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 99) == 0), $urandom_range(0, 3) != 0,
                 ($urandom_range(0, 7) == 0) ? 8'h00 : WIDTH'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom),
                 $urandom_range(0, 3) != 0, 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
Downstream stage of the ALU bitwise/carry unit.
- Captures each ALU result byte and carry-out.
- Updates the architectural accumulator, carry and zero flags.
- Optionally queues the result, with its carry, into a small FIFO for the store/register-file path, using a valid/ready handshake.
- Drives the registered carry flag back to the ALU as next-operation carry-in.

Parameters:
WIDTH, 8, datapath width of result byte and accumulator
DEPTH, 2, output FIFO entries (power of two, >=2)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  ALU result present this cycle
in_ready  out  1  stage can accept a result
in_q  in  WIDTH  ALU result byte
in_cout  in  1  ALU carry-out (already post-inversion)
wr_acc  in  1  on accept: load accumulator and zero flag
wr_carry  in  1  on accept: load carry flag
wr_out  in  1  on accept: push {in_q,in_cout} into output FIFO
acc  out  WIDTH  accumulator register
carry  out  1  carry flag; feeds ALU cin
zero  out  1  zero flag (accumulator==0)
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer takes head entry
out_q  out  WIDTH  FIFO head result
out_cout  out  1  FIFO head carry

Behaviour:
- Reset (rst=1 at edge, overrides all other activity, including a handshake in progress):
  - acc=0, carry=0, zero=1, FIFO count=0, read/write pointers=0.
  - out_valid=0; out_q=0, out_cout=0 on the first cycle after reset.
- in_ready = (count != DEPTH).
  - Depends only on registered state; no combinational path from out_ready or in_valid.
- accept = in_valid & in_ready. Control bits wr_* are sampled only on accept and ignored otherwise.
- On accept, each update happens independently on the edge:
  - wr_acc: acc<=in_q, zero<=(in_q==0).
  - wr_carry: carry<=in_cout.
  - wr_out: FIFO[wptr]<={in_q,in_cout}, wptr<=wptr+1 mod DEPTH.
- Accept with all wr_*=0 is legal and is a no-op that consumes the beat.
- Latency: acc/carry/zero visible the cycle after accept. A pushed entry is visible at out_* no earlier than the cycle after accept; there is no fall-through.
- out_valid = (count != 0). out_q/out_cout = FIFO[rptr], combinational from storage.
  - When empty, out_q/out_cout hold the last head value and must be stable.
- pop = out_valid & out_ready. Then rptr<=rptr+1 mod DEPTH.
- count update:
  - push&!pop: +1
  - pop&!push: -1
  - push&pop: unchanged
  - Push and pop in the same cycle are legal at any count where in_ready=1.
  - At count==DEPTH a push cannot occur (in_ready=0), even if out_ready=1 that cycle. Pop proceeds and in_ready rises next cycle.
- Entries leave the FIFO in push order. Pointer wrap is modulo DEPTH and must not corrupt data.
- Back-to-back dependency: result accepted at cycle n with wr_carry drives carry (cin) at cycle n+1. No bypass of in_cout to carry.
- Stall safety: out_q/out_cout/out_valid must not change while out_valid=1 and out_ready=0, except by reset.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1, wr_*=1, in_q=8'hFF -> acc=0, carry=0, zero=1, out_valid=0, in_ready=1.
- Accumulator/flags: accept in_q=8'h00, in_cout=1, wr_acc=1, wr_carry=1 -> next cycle acc=00, zero=1, carry=1. Then accept in_q=8'h5A, wr_acc=1, wr_carry=0, in_cout=0 -> acc=5A, zero=0, carry stays 1.
- FIFO fill/stall: out_ready=0; push 8'h11/c0 then 8'h22/c1 -> in_ready=0 after 2nd accept, out_q=11, out_cout=0. Third in_valid with 8'h33 is not accepted; acc is unchanged even with wr_acc=1.
- Full with simultaneous ready: FIFO full, in_valid=1 (8'h33), out_ready=1 -> pop 11, no push. Next cycle in_ready=1, 33 accepted. Drain order 22, 33.
- Wrap and concurrent push/pop: out_ready=1 constantly, stream 8'h01..8'h08 with wr_out=1 -> out sequence 01..08 each one cycle after accept, count never exceeds 1, no drops/duplicates across pointer wrap.
- Reset mid-operation: FIFO holding 2 entries, carry=1, assert rst one cycle -> out_valid=0, carry=0, acc=0. Subsequent push 8'hA5 appears at out_q alone.
